// File: rtl/mpc_mul_share_sched_pkg.sv
// Shared constants and tag type for the time-shared MPC multiplier scheduler.
package mpc_mul_share_sched_pkg;

    localparam int NREQ    = 4;
    localparam int A_W     = 21;
    localparam int B_W     = 14;
    localparam int P_W     = 35;
    localparam int MUL_LAT = 4;
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One operand register stage in front of the multiplier pipeline.
    localparam int TAG_LEN = MUL_LAT + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Empty pipeline slot; the id is zeroed so bubbles never carry stale tags.
    function automatic tag_t tag_bubble();
        tag_t t;
        t.valid = 1'b0;
        t.id    = '0;
        return t;
    endfunction

endpackage

// File: rtl/mpc_mul_share_sched_if.sv
// Requester and response bundle between the solver loops and the scheduler.
interface mpc_mul_share_sched_if
    import mpc_mul_share_sched_pkg::*;
();

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [P_W-1:0]      rsp_data;
    logic                rsp_ready;

    // Requester / response-sink side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/mpc_mul_share_sched_arb.sv
// N-wide round-robin arbiter: one grant per enabled cycle, pointer moves past the winner.
module mpc_mul_share_sched_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_id,
    output logic          o_xfer
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [N-1:0]  w_gnt;
    logic [IW-1:0] w_gnt_id;
    logic          w_found;

    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % N;
    endfunction

    // Search from the pointer upward, wrapping, and grant the first valid requester.
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (i_en && !w_found && i_req[wrap_idx(int'(r_ptr), k)]) begin
                w_gnt[wrap_idx(int'(r_ptr), k)] = 1'b1;
                w_gnt_id = IW'(wrap_idx(int'(r_ptr), k));
                w_found  = 1'b1;
            end else begin
            end
        end
    end

    // Next pointer is one past the winner, modulo N.
    always_comb begin
        if (int'(w_gnt_id) == N - 1) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_id + IW'(1);
        end
    end

    // Pointer only advances on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt    = w_gnt;
    assign o_gnt_id = w_gnt_id;
    // Grants only go to valid requesters, so every grant is a transfer.
    assign o_xfer   = w_found;

endmodule

// File: rtl/mpc_mul_share_sched.sv
// Time-shares one pipelined signed x unsigned multiplier among NREQ requesters.
// The tag pipe shadows the operand register plus the multiplier stages; both
// advance only on mul_ce, so the tag at the end always belongs to mul_p.
module mpc_mul_share_sched
    import mpc_mul_share_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    mpc_mul_share_sched_if.slave  bus,
    output logic [A_W-1:0]        o_mul_a,
    output logic [B_W-1:0]        o_mul_b,
    output logic                  o_mul_ce,
    input  logic [P_W-1:0]        i_mul_p,
    output logic                  o_busy
);

    if (P_W != A_W + B_W) begin : g_pw_check
        $error("product width must equal A_W + B_W");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
        $error("NREQ must be within 2..8");
    end

    tag_t            r_tag [TAG_LEN];
    logic [A_W-1:0]  r_mul_a;
    logic [B_W-1:0]  r_mul_b;

    logic            w_stall;
    logic            w_ce;
    logic            w_arb_en;
    logic [NREQ-1:0] w_gnt;
    logic [ID_W-1:0] w_gnt_id;
    logic            w_xfer;
    logic [A_W-1:0]  w_sel_a;
    logic [B_W-1:0]  w_sel_b;
    logic            w_busy;

    // A held response freezes the whole pipe, multiplier included.
    assign w_stall  = r_tag[TAG_LEN-1].valid & ~bus.rsp_ready;
    assign w_ce     = ~w_stall;
    // No grant while reset is asserted, so nothing is handshaken into a cleared pipe.
    assign w_arb_en = w_ce & rst_n;

    mpc_mul_share_sched_arb #(
        .N  (NREQ),
        .IW (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (bus.req_valid),
        .i_en     (w_arb_en),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_xfer   (w_xfer)
    );

    // Route the granted requester's operands toward the operand register.
    always_comb begin
        w_sel_a = bus.req_a[int'(w_gnt_id) * A_W +: A_W];
        w_sel_b = bus.req_b[int'(w_gnt_id) * B_W +: B_W];
    end

    // Operand register and tag shift register, advancing in lockstep with mul_ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_LEN; i++) begin
                r_tag[i] <= tag_bubble();
            end
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_ce) begin
            r_tag[0].valid <= w_xfer;
            r_tag[0].id    <= w_gnt_id;
            for (int i = 1; i < TAG_LEN; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            if (w_xfer) begin
                r_mul_a <= w_sel_a;
                r_mul_b <= w_sel_b;
            end else begin
                r_mul_a <= r_mul_a;
                r_mul_b <= r_mul_b;
            end
        end else begin
            for (int i = 0; i < TAG_LEN; i++) begin
                r_tag[i] <= r_tag[i];
            end
            r_mul_a <= r_mul_a;
            r_mul_b <= r_mul_b;
        end
    end

    // Busy whenever any tag stage holds a live operation.
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < TAG_LEN; i++) begin
            w_busy = w_busy | r_tag[i].valid;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = r_tag[TAG_LEN-1].valid;
    assign bus.rsp_id    = r_tag[TAG_LEN-1].id;
    assign bus.rsp_data  = i_mul_p;
    assign o_mul_a       = r_mul_a;
    assign o_mul_b       = r_mul_b;
    assign o_mul_ce      = w_ce;
    assign o_busy        = w_busy;

endmodule

// File: tb/tb_mpc_mul_share_sched.sv
// Directed and randomized checks for the multiplier share scheduler, with a
// behavioural ce-gated multiplier standing in for the external instance.
module tb_mpc_mul_share_sched;
    import mpc_mul_share_sched_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [A_W-1:0] mul_a;
    logic [B_W-1:0] mul_b;
    logic           mul_ce;
    logic [P_W-1:0] mul_p;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpc_mul_share_sched_if bus ();

    mpc_mul_share_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .o_mul_a  (mul_a),
        .o_mul_b  (mul_b),
        .o_mul_ce (mul_ce),
        .i_mul_p  (mul_p),
        .o_busy   (busy)
    );

    function automatic logic [P_W-1:0] prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic signed [63:0] pa, pb, pr;
        pa = 64'($signed(a));
        pb = 64'(b);
        pr = pa * pb;
        return pr[P_W-1:0];
    endfunction

    logic [P_W-1:0] mstage [MUL_LAT];

    // Multiplier model: MUL_LAT ce-enabled stages from operand sample to dout.
    always @(posedge clk) begin
        if (mul_ce) begin
            mstage[0] <= prod(mul_a, mul_b);
            for (int i = 1; i < MUL_LAT; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_p = mstage[MUL_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        bus.req_a[i*A_W +: A_W] = a;
        bus.req_b[i*B_W +: B_W] = b;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [A_W-1:0]  ta [NREQ];
    logic [B_W-1:0]  tb_b [NREQ];
    logic [A_W-1:0]  t4a [3];
    logic [B_W-1:0]  t4b [3];
    logic            mv  [TAG_LEN];
    logic [ID_W-1:0] mid [TAG_LEN];
    logic [P_W-1:0]  mp  [TAG_LEN];
    int              mptr;
    logic            m_stall;
    logic            g_found;
    logic [ID_W-1:0] g_id;
    logic [NREQ-1:0] exp_gnt;
    logic [P_W-1:0]  g_prod;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        #12;
        // Reset state, with every requester asserting valid.
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ce", mul_ce, 1);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single op from requester 0: -3 * 7.
        bus.req_valid = 4'b0001;
        set_req(0, -21'sd3, 14'd7);
        #1;
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_ce", mul_ce, 1);
        tick();
        bus.req_valid = '0;
        #1;
        chk("t1_mul_a", $signed(mul_a), -3);
        chk("t1_mul_b", mul_b, 7);
        chk("t1_busy", busy, 1);
        chk("t1_rsp_idle", bus.rsp_valid, 0);
        tick(); tick(); tick();
        chk("t1_early", bus.rsp_valid, 0);
        tick();
        chk("t1_rsp_valid", bus.rsp_valid, 1);
        chk("t1_rsp_id", bus.rsp_id, 0);
        chk("t1_rsp_data", $signed(bus.rsp_data), -21);
        tick();
        chk("t1_after", bus.rsp_valid, 0);
        chk("t1_busy_end", busy, 0);

        // All four requesters held valid for 8 cycles.
        do_reset();
        ta[0] = -21'sd1000;  tb_b[0] = 14'd3;
        ta[1] = 21'sd2047;   tb_b[1] = 14'd9999;
        ta[2] = -21'sd77;    tb_b[2] = 14'd16383;
        ta[3] = 21'sd500000; tb_b[3] = 14'd1;
        for (int i = 0; i < NREQ; i++) set_req(i, ta[i], tb_b[i]);
        for (int cyc = 0; cyc < 14; cyc++) begin
            bus.req_valid = (cyc < 8) ? 4'hF : 4'h0;
            #1;
            if (cyc < 8) chk("t2_gnt", bus.req_ready, 4'b0001 << (cyc % 4));
            if (cyc >= 5 && cyc < 13) begin
                chk("t2_rsp_valid", bus.rsp_valid, 1);
                chk("t2_rsp_id", bus.rsp_id, (cyc - 5) % 4);
                chk("t2_rsp_data", $signed(bus.rsp_data),
                    $signed(prod(ta[(cyc-5)%4], tb_b[(cyc-5)%4])));
            end else begin
                chk("t2_rsp_gap", bus.rsp_valid, 0);
            end
            tick();
        end

        // Operand extremes, back to back from requesters 2 and 3.
        bus.req_valid = 4'b0100;
        set_req(2, 21'h100000, 14'h3FFF);
        #1;
        chk("t3_gnt2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1000;
        set_req(3, 21'h0FFFFF, 14'h3FFF);
        #1;
        chk("t3_gnt3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        tick(); tick(); tick();
        chk("t3_min_id", bus.rsp_id, 2);
        chk("t3_min_data", $signed(bus.rsp_data), -64'sd17178820608);
        tick();
        chk("t3_max_id", bus.rsp_id, 3);
        chk("t3_max_data", $signed(bus.rsp_data), 64'sd17178804225);
        tick();
        chk("t3_end", bus.rsp_valid, 0);

        // Requester 1 every cycle, then a 3-cycle sink stall.
        t4a[0] = 21'd5; t4b[0] = 14'd100;
        t4a[1] = 21'd6; t4b[1] = 14'd200;
        t4a[2] = 21'd7; t4b[2] = 14'd300;
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'b0010;
            set_req(1, t4a[k], t4b[k]);
            #1;
            chk("t4_gnt1", bus.req_ready, 4'b0010);
            tick();
        end
        bus.req_valid = '0;
        tick(); tick();
        chk("t4_rsp0_valid", bus.rsp_valid, 1);
        chk("t4_rsp0_data", $signed(bus.rsp_data), 500);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        set_req(0, -21'sd2, 14'd9);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("t4_stall_ce", mul_ce, 0);
            chk("t4_stall_ready", bus.req_ready, 0);
            chk("t4_stall_valid", bus.rsp_valid, 1);
            chk("t4_stall_id", bus.rsp_id, 1);
            chk("t4_stall_data", $signed(bus.rsp_data), 500);
            chk("t4_stall_busy", busy, 1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("t4_release_gnt", bus.req_ready, 4'b0001);
        chk("t4_release_ce", mul_ce, 1);
        chk("t4_release_data", $signed(bus.rsp_data), 500);
        tick();
        bus.req_valid = '0;
        #1;
        chk("t4_rsp1_id", bus.rsp_id, 1);
        chk("t4_rsp1_data", $signed(bus.rsp_data), 1200);
        tick();
        chk("t4_rsp2_data", $signed(bus.rsp_data), 2100);
        tick();
        chk("t4_bubble_a", bus.rsp_valid, 0);
        tick();
        chk("t4_bubble_b", bus.rsp_valid, 0);
        tick();
        chk("t4_late_valid", bus.rsp_valid, 1);
        chk("t4_late_id", bus.rsp_id, 0);
        chk("t4_late_data", $signed(bus.rsp_data), -18);
        tick();
        chk("t4_end_busy", busy, 0);

        // Reset with four operations in flight.
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 4'hF;
            #1;
            chk("t5_gnt", bus.req_ready, 4'b0001 << ((k + 1) % 4));
            tick();
        end
        bus.req_valid = '0;
        chk("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_valid_rst", bus.rsp_valid, 0);
        chk("t5_ce_rst", mul_ce, 1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t5_no_stale", bus.rsp_valid, 0);
            tick();
        end
        bus.req_valid = 4'b1000;
        set_req(3, 21'd123, 14'd45);
        #1;
        chk("t5_gnt3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        tick(); tick(); tick();
        chk("t5_early", bus.rsp_valid, 0);
        tick();
        chk("t5_id", bus.rsp_id, 3);
        chk("t5_data", $signed(bus.rsp_data), 5535);

        // Random traffic against a cycle model of arbiter, tag pipe and stall.
        do_reset();
        mptr = 0;
        for (int i = 0; i < TAG_LEN; i++) begin
            mv[i] = 1'b0; mid[i] = '0; mp[i] = '0;
        end
        for (int cyc = 0; cyc < 2010; cyc++) begin
            if (cyc < 2000) begin
                bus.req_valid = NREQ'($urandom_range(0, 15));
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NREQ; i++) set_req(i, A_W'($urandom), B_W'($urandom));
            end else begin
                bus.req_valid = '0;
                bus.rsp_ready = 1'b1;
            end
            #1;
            m_stall = mv[TAG_LEN-1] && !bus.rsp_ready;
            exp_gnt = '0;
            g_found = 1'b0;
            g_id = '0;
            if (!m_stall) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!g_found && bus.req_valid[(mptr + k) % NREQ]) begin
                        g_found = 1'b1;
                        g_id = ID_W'((mptr + k) % NREQ);
                        exp_gnt[(mptr + k) % NREQ] = 1'b1;
                    end
                end
            end
            g_prod = prod(bus.req_a[int'(g_id)*A_W +: A_W], bus.req_b[int'(g_id)*B_W +: B_W]);
            chk("rnd_gnt", bus.req_ready, exp_gnt);
            chk("rnd_ce", mul_ce, !m_stall);
            chk("rnd_valid", bus.rsp_valid, mv[TAG_LEN-1]);
            if (mv[TAG_LEN-1]) begin
                chk("rnd_id", bus.rsp_id, mid[TAG_LEN-1]);
                chk("rnd_data", $signed(bus.rsp_data), $signed(mp[TAG_LEN-1]));
            end
            tick();
            if (!m_stall) begin
                for (int i = TAG_LEN - 1; i > 0; i--) begin
                    mv[i] = mv[i-1]; mid[i] = mid[i-1]; mp[i] = mp[i-1];
                end
                mv[0] = g_found; mid[0] = g_id; mp[0] = g_prod;
                if (g_found) mptr = (int'(g_id) + 1) % NREQ;
            end
        end
        chk("rnd_drain_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
